// File: rtl/csi_rx_pkg.sv
// Shared types for the CSI-2 RX clock-lane controller: FSM states, LP line
// states ({P,N}) and the registered output bundle decoded from each state.
package csi_rx_pkg;

    typedef enum logic [3:0] {
        ST_DISABLED,
        ST_STOP,
        ST_HS_RQST,
        ST_SETTLE,
        ST_HS_ACTIVE,
        ST_ULPS_RQST,
        ST_ULPS,
        ST_ULPS_EXIT,
        ST_ERR_WAIT
    } clk_lane_state_e;

    localparam logic [1:0] LP00 = 2'b00;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP10 = 2'b10;
    localparam logic [1:0] LP11 = 2'b11;

    typedef struct packed {
        logic hsrx_disable;
        logic div_clr;
        logic clk_hs_active;
        logic stop_state;
        logic ulps_active;
    } lane_out_t;

    // HS receiver is only enabled while settling or in HS; divider runs only in HS.
    function automatic lane_out_t state_outputs(input clk_lane_state_e s);
        lane_out_t o;
        o.hsrx_disable  = !(s == ST_SETTLE || s == ST_HS_ACTIVE);
        o.div_clr       = (s != ST_HS_ACTIVE);
        o.clk_hs_active = (s == ST_HS_ACTIVE);
        o.stop_state    = (s == ST_STOP);
        o.ulps_active   = (s == ST_ULPS);
        return o;
    endfunction

endpackage

// File: rtl/csi_rx_sync2.sv
// Two-flop synchronizer for one asynchronous LP receiver output, cleared low.
module csi_rx_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/csi_rx_clk_lane_ctrl.sv
// CSI-2 RX clock-lane LP/HS control FSM with LP glitch filter.
// Define CSI_RX_CLK_ERR_CNT_EN to add the saturating ERR_CNT output.
module csi_rx_clk_lane_ctrl
    import csi_rx_pkg::*;
#(
    parameter int FILT_CYC        = 2,
    parameter int TCLK_SETTLE_CYC = 16,
    parameter int CNT_W           = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic             LP_P,
    input  logic             LP_N,
    output logic             HSRX_DISABLE,
    output logic             DIV_CLR,
    output logic             CLK_HS_ACTIVE,
    output logic             STOP_STATE,
    output logic             ULPS_ACTIVE,
`ifdef CSI_RX_CLK_ERR_CNT_EN
    output logic [CNT_W-1:0] ERR_CNT,
`endif
    output logic             ERR_SEQ
);

    localparam int RUN_W = $clog2(FILT_CYC + 1);

    logic [1:0]       sync;
    logic [1:0]       cand;
    logic [1:0]       filt;
    logic [RUN_W-1:0] run_q, run_d;

    csi_rx_sync2 u_sync_p (.clk(CLK), .rst_n(RST_N), .d(LP_P), .q(sync[1]));
    csi_rx_sync2 u_sync_n (.clk(CLK), .rst_n(RST_N), .d(LP_N), .q(sync[0]));

    // run_q counts consecutive identical synchronized samples, saturating at FILT_CYC.
    always_comb begin
        run_d = RUN_W'(1);
        if (sync == cand)
            run_d = (run_q == RUN_W'(FILT_CYC)) ? run_q : run_q + RUN_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cand  <= LP00;
            run_q <= '0;
            filt  <= LP00;
        end else begin
            cand  <= sync;
            run_q <= run_d;
            if (run_d >= RUN_W'(FILT_CYC))
                filt <= sync;
        end
    end

    clk_lane_state_e  state, state_d;
    logic [CNT_W-1:0] settle_cnt, settle_d;
    logic             err_d;
    lane_out_t        out_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= ST_DISABLED;
            settle_cnt <= '0;
            out_q      <= state_outputs(ST_DISABLED);
            ERR_SEQ    <= 1'b0;
        end else begin
            state      <= state_d;
            settle_cnt <= settle_d;
            out_q      <= state_outputs(state_d);
            ERR_SEQ    <= err_d;
        end
    end

    always_comb begin
        state_d  = state;
        settle_d = settle_cnt;
        err_d    = 1'b0;
        if (!ENABLE) begin
            state_d = ST_DISABLED;
        end else begin
            case (state)
                ST_DISABLED:  if (filt == LP11) state_d = ST_STOP;
                ST_STOP: begin
                    if (filt == LP01)      state_d = ST_HS_RQST;
                    else if (filt == LP10) state_d = ST_ULPS_RQST;
                    else if (filt == LP00) begin state_d = ST_ERR_WAIT; err_d = 1'b1; end
                end
                ST_HS_RQST: begin
                    if (filt == LP00)      begin state_d = ST_SETTLE; settle_d = '0; end
                    else if (filt == LP11) state_d = ST_STOP;
                    else if (filt == LP10) begin state_d = ST_ERR_WAIT; err_d = 1'b1; end
                end
                // LP-11 wins over an expiring settle window.
                ST_SETTLE: begin
                    if (filt == LP11) begin
                        state_d = ST_ERR_WAIT;
                        err_d   = 1'b1;
                    end else if (settle_cnt == CNT_W'(TCLK_SETTLE_CYC - 1)) begin
                        state_d = ST_HS_ACTIVE;
                    end else begin
                        settle_d = settle_cnt + CNT_W'(1);
                    end
                end
                ST_HS_ACTIVE: if (filt == LP11) state_d = ST_STOP;
                ST_ULPS_RQST: begin
                    if (filt == LP00)      state_d = ST_ULPS;
                    else if (filt == LP11) state_d = ST_STOP;
                    else if (filt == LP01) begin state_d = ST_ERR_WAIT; err_d = 1'b1; end
                end
                ST_ULPS:      if (filt == LP10) state_d = ST_ULPS_EXIT;
                ST_ULPS_EXIT: if (filt == LP11) state_d = ST_STOP;
                ST_ERR_WAIT:  if (filt == LP11) state_d = ST_STOP;
                default:      state_d = ST_DISABLED;
            endcase
        end
    end

    assign HSRX_DISABLE  = out_q.hsrx_disable;
    assign DIV_CLR       = out_q.div_clr;
    assign CLK_HS_ACTIVE = out_q.clk_hs_active;
    assign STOP_STATE    = out_q.stop_state;
    assign ULPS_ACTIVE   = out_q.ulps_active;

`ifdef CSI_RX_CLK_ERR_CNT_EN
    always_ff @(posedge CLK) begin
        if (!RST_N)
            ERR_CNT <= '0;
        else if (err_d && ERR_CNT != '1)
            ERR_CNT <= ERR_CNT + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_csi_rx_clk_lane_ctrl.sv
// Randomized + directed scoreboard bench for csi_rx_clk_lane_ctrl.
module tb_csi_rx_clk_lane_ctrl;

    localparam int FILT = 2;
    localparam int TCLK = 8;
    localparam int CW   = 8;

    logic CLK = 1'b0;
    logic RST_N, ENABLE, LP_P, LP_N;
    logic HSRX_DISABLE, DIV_CLR, CLK_HS_ACTIVE, STOP_STATE, ULPS_ACTIVE, ERR_SEQ;
    logic [CW-1:0] err_cnt;

    always #5 CLK = ~CLK;

    csi_rx_clk_lane_ctrl #(.FILT_CYC(FILT), .TCLK_SETTLE_CYC(TCLK), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .LP_P(LP_P), .LP_N(LP_N),
        .HSRX_DISABLE(HSRX_DISABLE), .DIV_CLR(DIV_CLR), .CLK_HS_ACTIVE(CLK_HS_ACTIVE),
        .STOP_STATE(STOP_STATE), .ULPS_ACTIVE(ULPS_ACTIVE),
`ifdef CSI_RX_CLK_ERR_CNT_EN
        .ERR_CNT(err_cnt),
`endif
        .ERR_SEQ(ERR_SEQ)
    );
`ifndef CSI_RX_CLK_ERR_CNT_EN
    assign err_cnt = '0;
`endif

    // Lane modes of the reference model.
    localparam int M_DIS = 0, M_STOP = 1, M_HSR = 2, M_SET = 3, M_HS = 4;
    localparam int M_URQ = 5, M_ULPS = 6, M_UEX = 7, M_ERR = 8;

    typedef struct {
        logic [5:0] o;   // {hsrx_dis, div_clr, hs, stop, ulps, err}
        int         cnt;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_pass = 0;

    // Reference model state: transition table on the filtered LP line state.
    int         nxt_tbl[9][4];
    bit         err_tbl[9][4];
    logic [1:0] d1, d2, filt;
    logic [1:0] win[$];
    int         mode, settle_t, cyc, errs;
    bit         err_p;

    task automatic model_edge(input bit en, input bit rstn, input logic [1:0] lp, input string nm);
        exp_t e;
        int   nm_mode;
        bit   eq;
        cyc++;
        err_p = 0;
        if (!rstn) begin
            d1 = 2'b00; d2 = 2'b00; filt = 2'b00; win.delete();
            mode = M_DIS; errs = 0;
        end else begin
            if (!en) begin
                mode = M_DIS;
            end else begin
                nm_mode = nxt_tbl[mode][filt];
                err_p   = err_tbl[mode][filt];
                if (mode == M_SET && !err_p && (cyc - settle_t) == TCLK) nm_mode = M_HS;
                if (nm_mode == M_SET && mode != M_SET) settle_t = cyc;
                if (err_p && errs < (1 << CW) - 1) errs++;
                mode = nm_mode;
            end
            win.push_back(d2);
            if (win.size() > FILT) void'(win.pop_front());
            eq = (win.size() == FILT);
            foreach (win[i]) if (win[i] != win[0]) eq = 0;
            if (eq) filt = win[0];
            d2 = d1;
            d1 = lp;
        end
        e.o   = {!(mode == M_SET || mode == M_HS), mode != M_HS, mode == M_HS,
                 mode == M_STOP, mode == M_ULPS, err_p};
        e.cnt = errs;
        e.nm  = nm;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit en, input bit rstn, input logic [1:0] lp, input int n, input string nm);
        repeat (n) begin
            ENABLE = en;
            RST_N  = rstn;
            {LP_P, LP_N} = lp;
            model_edge(en, rstn, lp, nm);
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: outputs are registered, so every cycle presents a response.
    initial begin
        exp_t e;
        logic [5:0] got;
        bit ok;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {HSRX_DISABLE, DIV_CLR, CLK_HS_ACTIVE, STOP_STATE, ULPS_ACTIVE, ERR_SEQ};
                ok  = (got === e.o);
`ifdef CSI_RX_CLK_ERR_CNT_EN
                ok  = ok && (err_cnt === CW'(e.cnt));
`endif
                n_chk++;
                if (ok) n_pass++;
                else $display("FAIL %s t=%0t got {hsd,dcl,hs,stop,ulps,err}=%b cnt=%0d want %b cnt=%0d",
                              e.nm, $time, got, err_cnt, e.o, e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int lp, hold;
        for (int s = 0; s < 9; s++)
            for (int l = 0; l < 4; l++) begin
                nxt_tbl[s][l] = s;
                err_tbl[s][l] = 0;
            end
        nxt_tbl[M_DIS][3]  = M_STOP;
        nxt_tbl[M_STOP][1] = M_HSR;  nxt_tbl[M_STOP][2] = M_URQ;
        nxt_tbl[M_STOP][0] = M_ERR;  err_tbl[M_STOP][0] = 1;
        nxt_tbl[M_HSR][0]  = M_SET;  nxt_tbl[M_HSR][3]  = M_STOP;
        nxt_tbl[M_HSR][2]  = M_ERR;  err_tbl[M_HSR][2]  = 1;
        nxt_tbl[M_SET][3]  = M_ERR;  err_tbl[M_SET][3]  = 1;
        nxt_tbl[M_HS][3]   = M_STOP;
        nxt_tbl[M_URQ][0]  = M_ULPS; nxt_tbl[M_URQ][3]  = M_STOP;
        nxt_tbl[M_URQ][1]  = M_ERR;  err_tbl[M_URQ][1]  = 1;
        nxt_tbl[M_ULPS][2] = M_UEX;
        nxt_tbl[M_UEX][3]  = M_STOP;
        nxt_tbl[M_ERR][3]  = M_STOP;
        cyc = 0; settle_t = 0; mode = M_DIS; errs = 0;
        d1 = 0; d2 = 0; filt = 0;

        step(1, 0, 2'b11, 3,  "reset");
        step(1, 1, 2'b11, 10, "to_stop");
        step(1, 1, 2'b01, 10, "hs_rqst");
        step(1, 1, 2'b00, 20, "hs_settle");
        step(1, 1, 2'b11, 10, "hs_exit");
        step(1, 1, 2'b01, 1,  "glitch");
        step(1, 1, 2'b11, 10, "glitch_hold");
        step(1, 1, 2'b10, 10, "ulps_rqst");
        step(1, 1, 2'b00, 10, "ulps");
        step(1, 1, 2'b10, 10, "ulps_exit");
        step(1, 1, 2'b11, 10, "ulps_stop");
        repeat (3) begin
            step(1, 1, 2'b00, 10, "err3");
            step(1, 1, 2'b11, 10, "err3_rec");
        end
        step(1, 1, 2'b01, 10, "en_hs_rqst");
        step(1, 1, 2'b00, 20, "en_hs");
        step(0, 1, 2'b00, 3,  "en_low_hs");
        step(1, 1, 2'b11, 10, "en_back");
        step(1, 1, 2'b01, 10, "rst_hs_rqst");
        step(1, 1, 2'b00, 8,  "rst_settle");
        step(1, 0, 2'b00, 2,  "rst_in_settle");
        step(1, 1, 2'b11, 10, "rst_back");
        repeat (300) begin
            step(1, 1, 2'b00, 5, "err300");
            step(1, 1, 2'b11, 5, "err300_rec");
        end
        step(0, 1, 2'b11, 2,  "rand_pre");
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                step(1, 1, 2'b11, $urandom_range(4, 8), "rand_hs");
                step(1, 1, 2'b01, $urandom_range(2, 8), "rand_hs");
                step(1, 1, 2'b00, $urandom_range(2, 20), "rand_hs");
            end else begin
                lp   = $urandom_range(0, 3);
                hold = $urandom_range(1, 14);
                step($urandom_range(0, 24) != 0, $urandom_range(0, 60) != 0,
                     2'(lp), hold, "rand");
            end
        end
        step(1, 1, 2'b11, 10, "final");

        @(negedge CLK);
        @(negedge CLK);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
